music_sheet_player: RTL and testbench

MUSIC_SHEET_PLAYER -- requirements
Module: music_sheet_player

---
 rtl/music_sheet_player.sv | 126 ++++++++++++
 tb/tb_music_sheet_player.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/music_sheet_player.sv
// Four-step sequencer: plays the four bytes of a 32-bit sheet word as notes
// with a fixed step length and gate length. The sheet is latched at bar start.
module music_sheet_player #(
   parameter int CLK_PER_TICK   = 50000,
   parameter int TICKS_PER_STEP = 250,
   parameter int GATE_TICKS     = 200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] music_sheet,
   input  logic        run,
   output logic [6:0]  note,
   output logic        gate,
   output logic        note_on,
   output logic [1:0]  step,
   output logic        bar_start
);

   localparam int CW = $clog2(CLK_PER_TICK);
   localparam int TW = 10;
   localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_PER_TICK - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_STEP - 1);
   localparam logic [TW-1:0] GATE_AT   = TW'(GATE_TICKS);

   typedef enum logic {IDLE, PLAY} state_t;

   state_t        state, state_n;
   logic [31:0]   sheet_reg, sheet_n;
   logic [CW-1:0] clk_cnt, clk_n;
   logic [TW-1:0] tick_cnt, tick_n;
   logic [1:0]    step_n;
   logic [6:0]    note_n;
   logic          gate_n, note_on_n, bar_n;
   logic          load;
   logic [7:0]    sel;

   // State and output registers; everything visible is driven from here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sheet_reg <= '0;
         clk_cnt   <= '0;
         tick_cnt  <= '0;
         step      <= '0;
         note      <= '0;
         gate      <= 1'b0;
         note_on   <= 1'b0;
         bar_start <= 1'b0;
      end else begin
         state     <= state_n;
         sheet_reg <= sheet_n;
         clk_cnt   <= clk_n;
         tick_cnt  <= tick_n;
         step      <= step_n;
         note      <= note_n;
         gate      <= gate_n;
         note_on   <= note_on_n;
         bar_start <= bar_n;
      end
   end

   // Next-state: counters, step advance, bar wrap and step load.
   always_comb begin
      state_n   = state;
      sheet_n   = sheet_reg;
      clk_n     = clk_cnt;
      tick_n    = tick_cnt;
      step_n    = step;
      note_n    = note;
      gate_n    = gate;
      note_on_n = 1'b0;
      bar_n     = 1'b0;
      load      = 1'b0;
      sel       = 8'h00;

      if (state == IDLE || !run) begin
         // Idle, or a stop request: any step end due this cycle is dropped.
         state_n = IDLE;
         gate_n  = 1'b0;
         step_n  = 2'd0;
         clk_n   = '0;
         tick_n  = '0;
         if (state == IDLE && run) begin
            state_n = PLAY;
            sheet_n = music_sheet;
            bar_n   = 1'b1;
            load    = 1'b1;
            sel     = music_sheet[7:0];
         end
      end else if (clk_cnt != CLK_LAST) begin
         clk_n = clk_cnt + 1'b1;
      end else begin
         clk_n = '0;
         if (tick_cnt == TICK_LAST) begin
            tick_n = '0;
            step_n = step + 2'd1;
            load   = 1'b1;
            if (step == 2'd3) begin
               // Bar wrap: pick up the new sheet word on the same edge.
               sheet_n = music_sheet;
               bar_n   = 1'b1;
               sel     = music_sheet[7:0];
            end else begin
               sel = sheet_reg[{step_n, 3'b000} +: 8];
            end
         end else begin
            tick_n = tick_cnt + 1'b1;
            // Never matches when GATE_TICKS == TICKS_PER_STEP, so the gate
            // then stays high into the next step.
            if (tick_n == GATE_AT) gate_n = 1'b0;
         end
      end

      // Rest bytes silence the gate but keep the previous note code.
      if (load) begin
         if (sel[7]) begin
            gate_n = 1'b0;
         end else begin
            note_n    = sel[6:0];
            gate_n    = 1'b1;
            note_on_n = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_music_sheet_player.sv
// Directed bench: basic bar, rests, mid-bar sheet change, stop, async reset,
// and a second instance with the gate spanning the full step.
module tb_music_sheet_player;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] sheet, sheet2;
   logic        run, run2;
   logic [6:0]  note, note2;
   logic        gate, gate2, note_on, note_on2, bar_start, bar_start2;
   logic [1:0]  step, step2;

   int checks = 0;
   int failures = 0;
   int on_cnt, gh_cnt, bs_cnt, on2_cnt, glow2_cnt;

   music_sheet_player #(.CLK_PER_TICK(4), .TICKS_PER_STEP(3), .GATE_TICKS(2)) u1 (
      .clk(clk), .reset_n(reset_n), .music_sheet(sheet), .run(run),
      .note(note), .gate(gate), .note_on(note_on), .step(step), .bar_start(bar_start)
   );

   music_sheet_player #(.CLK_PER_TICK(4), .TICKS_PER_STEP(3), .GATE_TICKS(3)) u2 (
      .clk(clk), .reset_n(reset_n), .music_sheet(sheet2), .run(run2),
      .note(note2), .gate(gate2), .note_on(note_on2), .step(step2), .bar_start(bar_start2)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n clock edges, sampling 1 time unit after each edge.
   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         on_cnt    += int'(note_on);
         gh_cnt    += int'(gate);
         bs_cnt    += int'(bar_start);
         on2_cnt   += int'(note_on2);
         glow2_cnt += int'(!gate2);
      end
   endtask

   task automatic clr();
      on_cnt = 0; gh_cnt = 0; bs_cnt = 0; on2_cnt = 0; glow2_cnt = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      run = 1'b0; run2 = 1'b0;
      sheet = 32'h0; sheet2 = 32'h0;
      clr();
      #12;
      chk("rst_note", 32'(note), 32'h0);
      chk("rst_gate", 32'(gate), 32'h0);
      chk("rst_step", 32'(step), 32'h0);
      reset_n = 1'b1;
      adv(3);
      chk("idle_gate", 32'(gate), 32'h0);
      chk("idle_bar", 32'(bar_start), 32'h0);

      // Basic bar with a sheet change during step 1
      sheet = 32'h3C3E4045;
      run = 1'b1;
      adv(1);
      chk("e0_note", 32'(note), 32'h45);
      chk("e0_gate", 32'(gate), 32'h1);
      chk("e0_on", 32'(note_on), 32'h1);
      chk("e0_bar", 32'(bar_start), 32'h1);
      chk("e0_step", 32'(step), 32'h0);
      clr();
      adv(1);
      chk("e1_on", 32'(note_on), 32'h0);
      chk("e1_bar", 32'(bar_start), 32'h0);
      adv(6);
      chk("e7_gate", 32'(gate), 32'h1);
      adv(1);
      chk("e8_gate", 32'(gate), 32'h0);
      adv(4);
      chk("e12_step", 32'(step), 32'h1);
      chk("e12_note", 32'(note), 32'h40);
      chk("e12_on", 32'(note_on), 32'h1);
      adv(1);
      sheet = 32'h11111111;
      adv(11);
      chk("e24_step", 32'(step), 32'h2);
      chk("e24_note", 32'(note), 32'h3E);
      adv(12);
      chk("e36_step", 32'(step), 32'h3);
      chk("e36_note", 32'(note), 32'h3C);
      adv(12);
      chk("e48_step", 32'(step), 32'h0);
      chk("e48_note", 32'(note), 32'h11);
      chk("e48_bar", 32'(bar_start), 32'h1);
      chk("bar_on_cnt", 32'(on_cnt), 32'd4);
      chk("bar_gate_cnt", 32'(gh_cnt), 32'd32);
      chk("bar_bs_cnt", 32'(bs_cnt), 32'd1);

      // Stop, then replay with rests
      run = 1'b0;
      adv(1);
      chk("stop_gate", 32'(gate), 32'h0);
      chk("stop_note_hold", 32'(note), 32'h11);
      sheet = 32'h80408040;
      run = 1'b1;
      adv(1);
      chk("r0_note", 32'(note), 32'h40);
      chk("r0_on", 32'(note_on), 32'h1);
      adv(12);
      chk("r1_step", 32'(step), 32'h1);
      chk("r1_gate", 32'(gate), 32'h0);
      chk("r1_on", 32'(note_on), 32'h0);
      chk("r1_note", 32'(note), 32'h40);
      adv(12);
      chk("r2_gate", 32'(gate), 32'h1);
      chk("r2_on", 32'(note_on), 32'h1);
      adv(12);
      chk("r3_gate", 32'(gate), 32'h0);
      chk("r3_on", 32'(note_on), 32'h0);

      // Stop mid-gate at cycle 5 of a fresh bar
      run = 1'b0;
      adv(1);
      sheet = 32'h3C3E4045;
      run = 1'b1;
      adv(1);
      adv(5);
      chk("s5_gate", 32'(gate), 32'h1);
      run = 1'b0;
      adv(1);
      chk("s6_gate", 32'(gate), 32'h0);
      chk("s6_step", 32'(step), 32'h0);
      clr();
      adv(20);
      chk("stopped_on_cnt", 32'(on_cnt), 32'd0);
      chk("stopped_gate_cnt", 32'(gh_cnt), 32'd0);
      run = 1'b1;
      adv(1);
      chk("rerun_step", 32'(step), 32'h0);
      chk("rerun_bar", 32'(bar_start), 32'h1);
      chk("rerun_note", 32'(note), 32'h45);

      // Async reset between edges, mid-gate in step 1
      adv(14);
      chk("pre_rst_step", 32'(step), 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_note", 32'(note), 32'h0);
      chk("arst_gate", 32'(gate), 32'h0);
      chk("arst_step", 32'(step), 32'h0);
      adv(2);
      chk("arst_hold_gate", 32'(gate), 32'h0);
      run = 1'b0;
      #2;
      reset_n = 1'b1;
      adv(2);
      chk("post_rst_idle", 32'(gate), 32'h0);
      chk("post_rst_note", 32'(note), 32'h0);
      run = 1'b1;
      adv(1);
      chk("post_rst_play", 32'(note), 32'h45);
      chk("post_rst_bar", 32'(bar_start), 32'h1);

      // Full-length gate on the second instance
      sheet2 = 32'h01020304;
      run2 = 1'b1;
      adv(1);
      chk("g3_e0_note", 32'(note2), 32'h04);
      chk("g3_e0_gate", 32'(gate2), 32'h1);
      clr();
      adv(12);
      chk("g3_e12_note", 32'(note2), 32'h03);
      adv(36);
      chk("g3_gate_low_cnt", 32'(glow2_cnt), 32'd0);
      chk("g3_on_cnt", 32'(on2_cnt), 32'd4);
      chk("g3_e48_bar", 32'(bar_start2), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
